// File: rtl/imem_fetch_port_pkg.sv
// Shared definitions for the instruction-memory fetch port: the NOP encoding and the
// fetch error codes that the core also decodes.
package imem_fetch_port_pkg;

  localparam logic [31:0] RV_NOP = 32'h0000_0013;  // addi x0,x0,0

  typedef enum logic [1:0] {
    IMEM_OK       = 2'b00,
    IMEM_MISALIGN = 2'b01,
    IMEM_RANGE    = 2'b10
  } imem_err_e;

  // Misalignment wins over out-of-range.
  function automatic imem_err_e imem_classify(input logic [1:0] lo_bits, input logic oor);
    if (lo_bits != 2'b00) return IMEM_MISALIGN;
    if (oor)              return IMEM_RANGE;
    return IMEM_OK;
  endfunction

endpackage

// File: rtl/imem_fetch_port_if.sv
// Fetch request/response bundle between the PC stage (master) and the instruction
// memory (slave), including the branch-redirect flush.
interface imem_fetch_port_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              flush;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_data;
  logic [ADDR_W-1:0] rsp_addr;
  logic [1:0]        rsp_err;

  modport master (
    output req_valid, req_addr, flush, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_addr, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, flush, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_addr, rsp_err
  );
endinterface

// File: rtl/imem_pipe_stage.sv
// One fetch pipeline register {valid,data,addr,err}. Flush only drops the valid bit;
// the payload is don't-care once invalid.
module imem_pipe_stage #(
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              hold_i,
  input  logic              flush_i,
  input  logic              valid_i,
  input  logic [31:0]       data_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [1:0]        err_i,
  output logic              valid_o,
  output logic [31:0]       data_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [1:0]        err_o
);
  logic              valid_q;
  logic [31:0]       data_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      addr_q  <= '0;
      err_q   <= 2'b00;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (!hold_i) begin
      valid_q <= valid_i;
      data_q  <= data_i;
      addr_q  <= addr_i;
      err_q   <= err_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign addr_o  = addr_q;
  assign err_o   = err_q;
endmodule

// File: rtl/imem_fetch_port.sv
// Clocked RV32 instruction memory with a valid/ready fetch port, LATENCY-deep response
// pipeline, redirect flush and a run-time program-load write port.
module imem_fetch_port
  import imem_fetch_port_pkg::*;
#(
  parameter int          ADDR_W   = 32,
  parameter int          DEPTH    = 256,
  parameter int          LATENCY  = 1,
  parameter logic [31:0] NOP_INSN = RV_NOP
) (
  input  logic                     clk,
  input  logic                     rst,
  imem_fetch_port_if.slave         bus,
  input  logic                     prog_we,
  input  logic [$clog2(DEPTH)-1:0] prog_addr,
  input  logic [31:0]              prog_data
);
  localparam int IDX_W = $clog2(DEPTH);

  logic [31:0] mem [0:DEPTH-1];

  // Index 0 is the combinational read result feeding stage 1; index LATENCY drives rsp_*.
  logic [LATENCY:0]             vld_pipe;
  logic [LATENCY:0][31:0]       dat_pipe;
  logic [LATENCY:0][ADDR_W-1:0] adr_pipe;
  logic [LATENCY:0][1:0]        err_pipe;

  logic              stall, hold, accept, oor;
  logic [ADDR_W-3:0] word;
  imem_err_e         req_err;

  assign stall         = vld_pipe[LATENCY] & ~bus.rsp_ready;
  assign hold          = stall & ~bus.flush;
  assign bus.req_ready = ~stall | bus.flush;
  assign accept        = bus.req_valid & bus.req_ready;

  assign word    = bus.req_addr[ADDR_W-1:2];
  assign oor     = 64'(word) >= 64'(DEPTH);
  assign req_err = imem_classify(bus.req_addr[1:0], oor);

  // Read-first: the write below lands at the edge, so a same-cycle fetch sees the old word.
  always_ff @(posedge clk) begin
    if (!rst && prog_we) mem[prog_addr] <= prog_data;
  end

  assign vld_pipe[0] = accept;
  assign dat_pipe[0] = (req_err == IMEM_OK) ? mem[bus.req_addr[IDX_W+1:2]] : NOP_INSN;
  assign adr_pipe[0] = bus.req_addr;
  assign err_pipe[0] = req_err;

  for (genvar s = 1; s <= LATENCY; s++) begin : g_stage
    // Stage 1 is never flushed: during a flush it captures the redirect target instead.
    localparam bit CLR = (s > 1);
    imem_pipe_stage #(.ADDR_W(ADDR_W)) u_stage (
      .clk_i   (clk),
      .rst_i   (rst),
      .hold_i  (hold),
      .flush_i (bus.flush & CLR),
      .valid_i (vld_pipe[s-1]),
      .data_i  (dat_pipe[s-1]),
      .addr_i  (adr_pipe[s-1]),
      .err_i   (err_pipe[s-1]),
      .valid_o (vld_pipe[s]),
      .data_o  (dat_pipe[s]),
      .addr_o  (adr_pipe[s]),
      .err_o   (err_pipe[s])
    );
  end

  assign bus.rsp_valid = vld_pipe[LATENCY];
  assign bus.rsp_data  = dat_pipe[LATENCY];
  assign bus.rsp_addr  = adr_pipe[LATENCY];
  assign bus.rsp_err   = err_pipe[LATENCY];
endmodule
